// File: rtl/neuron_mac.sv
// neuron_mac: streaming fixed-point neuron that multiplies inputs by stored weights,
// accumulates with saturation and adds a bias. Four stages: align, multiply, accumulate, bias.
module neuron_mac #(
    parameter int numWeight    = 3,
    parameter int dataWidth    = 16,
    parameter int addressWidth = 10,
    parameter int fracBits     = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic signed [dataWidth-1:0]    myinput,
    input  logic                           myinputValid,
    input  logic signed [dataWidth-1:0]    bias,
    output logic                           wRen,
    output logic        [addressWidth-1:0] wRadd,
    input  logic signed [dataWidth-1:0]    wData,
    output logic signed [dataWidth-1:0]    out,
    output logic                           outValid
);
    localparam int PW = 2 * dataWidth;
    localparam logic signed [dataWidth-1:0] SAT_MAX = {1'b0, {(dataWidth-1){1'b1}}};
    localparam logic signed [dataWidth-1:0] SAT_MIN = {1'b1, {(dataWidth-1){1'b0}}};
    localparam logic [addressWidth-1:0] LAST_ADDR = addressWidth'(numWeight - 1);

    function automatic logic signed [dataWidth-1:0] sat_add(
        input logic signed [dataWidth-1:0] a,
        input logic signed [dataWidth-1:0] b
    );
        logic signed [dataWidth:0] s;
        s = {a[dataWidth-1], a} + {b[dataWidth-1], b};
        if (s[dataWidth] != s[dataWidth-1]) return s[dataWidth] ? SAT_MIN : SAT_MAX;
        return s[dataWidth-1:0];
    endfunction

    logic        [addressWidth-1:0] cnt_q, cnt_d;
    logic signed [dataWidth-1:0]    in1_q;
    logic                           v1_q, f1_q, l1_q;
    logic signed [PW-1:0]           prod_full, prod_sh;
    logic signed [dataWidth-1:0]    prod_d, p2_q;
    logic                           v2_q, f2_q, l2_q;
    logic signed [dataWidth-1:0]    acc_q, acc_d;
    logic                           l3_q;
    logic signed [dataWidth-1:0]    out_q, out_d;
    logic                           ov_q;

    always_comb begin
        cnt_d = cnt_q;
        if (myinputValid) cnt_d = (cnt_q == LAST_ADDR) ? '0 : cnt_q + addressWidth'(1);

        // Full-width product, rescaled; it fits only if the bits above the result are pure sign.
        prod_full = PW'(in1_q) * PW'(wData);
        prod_sh   = prod_full >>> fracBits;
        if (&prod_sh[PW-1:dataWidth-1] || ~|prod_sh[PW-1:dataWidth-1])
            prod_d = prod_sh[dataWidth-1:0];
        else
            prod_d = prod_sh[PW-1] ? SAT_MIN : SAT_MAX;

        acc_d = acc_q;
        if (v2_q) acc_d = f2_q ? p2_q : sat_add(acc_q, p2_q);

        out_d = out_q;
        if (l3_q) out_d = sat_add(acc_q, bias);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            in1_q <= '0;
            v1_q  <= 1'b0;
            f1_q  <= 1'b0;
            l1_q  <= 1'b0;
            p2_q  <= '0;
            v2_q  <= 1'b0;
            f2_q  <= 1'b0;
            l2_q  <= 1'b0;
            acc_q <= '0;
            l3_q  <= 1'b0;
            out_q <= '0;
            ov_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            in1_q <= myinput;
            v1_q  <= myinputValid;
            f1_q  <= myinputValid && (cnt_q == '0);
            l1_q  <= myinputValid && (cnt_q == LAST_ADDR);
            p2_q  <= prod_d;
            v2_q  <= v1_q;
            f2_q  <= f1_q;
            l2_q  <= l1_q;
            acc_q <= acc_d;
            l3_q  <= v2_q && l2_q;
            out_q <= out_d;
            ov_q  <= l3_q;
        end
    end

    assign wRen     = myinputValid && !rst;
    assign wRadd    = cnt_q;
    assign out      = out_q;
    assign outValid = ov_q;
endmodule

// File: tb/tb_neuron_mac.sv
// Bench for neuron_mac: directed vector table, reset-abort sequence and random vectors
// checked against an arithmetic model, with a weight memory and an output scoreboard.
module tb_neuron_mac;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] myinput;
    logic        myinputValid;
    logic [15:0] bias;
    logic        wRen;
    logic [9:0]  wRadd;
    logic [15:0] wData = '0;
    logic [15:0] out;
    logic        outValid;

    neuron_mac #(.numWeight(3), .dataWidth(16), .addressWidth(10), .fracBits(8)) dut (
        .clk(clk), .rst(rst), .myinput(myinput), .myinputValid(myinputValid), .bias(bias),
        .wRen(wRen), .wRadd(wRadd), .wData(wData), .out(out), .outValid(outValid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Weight memory with one cycle of read latency.
    logic [15:0] wmem [4];
    always @(posedge clk) if (wRen) wData <= wmem[wRadd[1:0]];

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q [$];
    int          cyc_q [$];
    logic [15:0] last_out = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (outValid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                logic [15:0] e;
                int c;
                e = exp_q.pop_front();
                c = cyc_q.pop_front();
                check("out", {16'd0, out}, {16'd0, e});
                check("pulse_cycle", cyc, c);
                last_out = e;
            end
        end
    end

    typedef struct {
        string            name;
        logic [2:0][15:0] w;
        logic [2:0][15:0] x;
        logic [15:0]      b;
        int               gap;
        int               idle_after;
        logic [15:0]      exp;
    } vec_t;

    function automatic vec_t mkvec(input string name, input logic [15:0] w0, w1, w2,
                                   input logic [15:0] x0, x1, x2, input logic [15:0] b,
                                   input int gap, input int idle_after, input logic [15:0] exp);
        vec_t v;
        v.name = name;
        v.w = {w2, w1, w0};
        v.x = {x2, x1, x0};
        v.b = b;
        v.gap = gap;
        v.idle_after = idle_after;
        v.exp = exp;
        return v;
    endfunction

    function automatic longint clampl(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Reference: Q8.8 products with floor scaling, saturating running sum, saturating bias add.
    function automatic logic [15:0] model(input vec_t v);
        longint acc;
        longint p;
        acc = 0;
        for (int i = 0; i < 3; i++) begin
            p = (longint'($signed(v.x[i])) * longint'($signed(v.w[i]))) >>> 8;
            acc = clampl(acc + clampl(p));
        end
        return 16'(clampl(acc + longint'($signed(v.b))));
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            myinputValid = 1'b0;
        end
    endtask

    task automatic apply_vector(input vec_t v);
        if (v.b !== bias) begin
            idle(4);
            bias = v.b;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            wmem[i] = v.w[i];
            myinput = v.x[i];
            myinputValid = 1'b1;
            #1;
            check({v.name, "_wradd"}, {22'd0, wRadd}, i);
            check({v.name, "_wren"}, {31'd0, wRen}, 32'd1);
            if (i == 2) begin
                exp_q.push_back(v.exp);
                cyc_q.push_back(cyc + 4);
            end else begin
                idle(v.gap);
            end
        end
        idle(v.idle_after);
    endtask

    vec_t vecs [6];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        logic [15:0] r;

        vecs[0] = mkvec("basic", 16'h0100, 16'h0200, 16'h0300, 16'h0100, 16'h0100, 16'h0100,
                        16'h0080, 0, 6, 16'h0680);
        vecs[1] = mkvec("gaps", 16'h0100, 16'h0200, 16'h0300, 16'h0100, 16'h0100, 16'h0100,
                        16'h0080, 2, 6, 16'h0680);
        vecs[2] = mkvec("sat_pos", 16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00,
                        16'h0000, 0, 6, 16'h7FFF);
        vecs[3] = mkvec("sat_neg", 16'h8100, 16'h8100, 16'h8100, 16'h7F00, 16'h7F00, 16'h7F00,
                        16'h0000, 0, 6, 16'h8000);
        vecs[4] = mkvec("b2b_a", 16'h0100, 16'h0200, 16'h0300, 16'h0100, 16'h0100, 16'h0100,
                        16'h0080, 0, 0, 16'h0680);
        vecs[5] = mkvec("b2b_b", 16'h0100, 16'h0200, 16'h0300, 16'hFF00, 16'hFF00, 16'hFF00,
                        16'h0080, 0, 6, 16'hFA80);
        for (int i = 0; i < 4; i++) wmem[i] = '0;

        // Reset state, with a valid input held to show it is ignored.
        rst = 1'b1;
        bias = 16'h0080;
        myinput = 16'h0100;
        myinputValid = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_wren", {31'd0, wRen}, 32'd0);
        check("rst_out", {16'd0, out}, 32'd0);
        check("rst_outvalid", {31'd0, outValid}, 32'd0);
        check("rst_wradd", {22'd0, wRadd}, 32'd0);
        rst = 1'b0;
        myinputValid = 1'b0;
        idle(2);

        for (int i = 0; i < 6; i++) apply_vector(vecs[i]);

        // Abort a vector with a one-cycle reset; its partial sum must never appear.
        idle(6);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            wmem[i] = 16'h7000;
            myinput = 16'h0100;
            myinputValid = 1'b1;
        end
        @(negedge clk);
        myinputValid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_out_cleared", {16'd0, out}, 32'd0);
        check("abort_wradd", {22'd0, wRadd}, 32'd0);
        apply_vector(vecs[0]);

        // Random vectors: mostly small values, some full-range ones that saturate.
        for (int n = 0; n < 40; n++) begin
            rv.name = "rand";
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 3) == 0) r = 16'($urandom_range(0, 65535));
                else r = 16'($urandom_range(0, 2047)) - 16'd1024;
                rv.w[i] = r;
                if ($urandom_range(0, 3) == 0) r = 16'($urandom_range(0, 65535));
                else r = 16'($urandom_range(0, 2047)) - 16'd1024;
                rv.x[i] = r;
            end
            rv.b = bias;
            if ($urandom_range(0, 4) == 0) begin
                case ($urandom_range(0, 2))
                    0: rv.b = 16'h0000;
                    1: rv.b = 16'h0080;
                    default: rv.b = 16'hFF00;
                endcase
            end
            rv.gap = $urandom_range(0, 2);
            rv.idle_after = $urandom_range(0, 3);
            rv.exp = model(rv);
            apply_vector(rv);
        end

        idle(1);
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        while (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            void'(cyc_q.pop_front());
            check("missing_pulse", 32'd0, 32'd1);
        end
        idle(3);
        check("out_hold", {16'd0, out}, {16'd0, last_out});
        check("idle_outvalid", {31'd0, outValid}, 32'd0);
        check("idle_wren", {31'd0, wRen}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/neuron_mac.md
NEURON_MAC -- requirements
Module: neuron_mac

Interface
REQ-001 SHALL provide parameter numWeight, default 3: inputs (and weights) per neuron vector.
REQ-002 SHALL provide parameter dataWidth, default 16: signed two's-complement word width for data, weights, bias and output.
REQ-003 SHALL provide parameter addressWidth, default 10: weight read address width.
REQ-004 SHALL provide parameter fracBits, default 8: fractional bits of the fixed-point format.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port myinput, input, dataWidth: input activation.
REQ-008 SHALL have port myinputValid, input, 1: myinput is valid this cycle.
REQ-009 SHALL have port bias, input, dataWidth: neuron bias; static while a vector is in flight.
REQ-010 SHALL have port wRen, output, 1: weight memory read enable.
REQ-011 SHALL have port wRadd, output, addressWidth: weight memory read address.
REQ-012 SHALL have port wData, input, dataWidth: weight memory read data, valid one cycle after wRen.
REQ-013 SHALL have port out, output, dataWidth: saturated neuron sum.
REQ-014 SHALL have port outValid, output, 1: single-cycle pulse marking out as new.

Function
REQ-015 SHALL drive wRen = myinputValid (combinational) and wRadd = the weight counter value.
REQ-016 SHALL increment the weight counter on each cycle with myinputValid=1, wrapping from numWeight-1 to 0.
REQ-017 SHALL register myinput and a "last" flag (counter == numWeight-1) for one cycle to align with wData.
REQ-018 SHALL, in stage 2, form the full signed 2*dataWidth product of aligned input and wData, arithmetic-shift it right by fracBits, saturate it to dataWidth, and register it with its valid, first and last flags.
REQ-019 SHALL, in stage 3, load the accumulator with the product when the first flag is set, otherwise add the product with saturation.
REQ-020 SHALL saturate on signed overflow: positive overflow -> 2^(dataWidth-1)-1; negative overflow -> -2^(dataWidth-1).
REQ-021 SHALL, in stage 4, when the last product has been accumulated, add bias with the same saturation, register the result to out and pulse outValid for exactly one cycle.
REQ-022 SHALL assert outValid exactly 4 cycles after the cycle in which the last input of a vector is sampled (last input in cycle T -> outValid in cycle T+4).
REQ-023 SHALL hold out at its last value between pulses.
REQ-024 SHALL accept gaps (myinputValid=0) of any length within a vector with no effect on the result.
REQ-025 SHALL accept back-to-back vectors with no bubble; the first product of a new vector starts a fresh sum.
REQ-026 SHALL, with numWeight=1, treat every input as both first and last.

Reset
REQ-027 SHALL, while rst=1, clear the counter, all pipeline valid/first/last flags, the accumulator, out and outValid to 0, and force wRen to 0.
REQ-028 SHALL discard a partially accumulated vector when reset mid-vector; no outValid pulse is produced for it.
REQ-029 SHALL start the first input after rst deasserts at weight address 0.

Verification (numWeight=3, dataWidth=16, fracBits=8, Q8.8)
REQ-030 SHALL verify the basic sum: weights 0x0100, 0x0200, 0x0300; inputs 0x0100 x3 on consecutive cycles; bias 0x0080 -> out=0x0680, outValid one cycle at T+4; wRadd sequence 0, 1, 2.
REQ-031 SHALL verify gaps: same stimulus with 2 idle cycles between inputs -> out=0x0680, with exactly one outValid pulse.
REQ-032 SHALL verify saturation: all weights and inputs 0x7F00, bias 0 -> out=0x7FFF; all weights 0x8100 and inputs 0x7F00 -> out=0x8000.
REQ-033 SHALL verify back-to-back vectors: vector A as in REQ-030 followed immediately by inputs 0xFF00 x3 (-1.0) -> outs 0x0680 then 0xFA80 (-6.0+0.5), pulses 3 cycles apart.
REQ-034 SHALL verify reset mid-vector: 2 inputs, then rst for 1 cycle, then a full REQ-030 vector -> no pulse for the aborted vector, wRadd restarts at 0, out=0x0680.
